// File: rtl/rvc_pkg.sv
// Shared constants, FSM state type and field helpers for the RV32I -> RVC packer.
package rvc_pkg;

  // RV32I major opcodes
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // funct3 values
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_W    = 3'b010;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRX  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;

  // funct7 values
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] RV_NOP    = 32'h0000_0013;
  localparam logic [31:0] RV_EBREAK = 32'h0010_0073;
  localparam logic [15:0] CNOP      = 16'h0001;
  localparam logic [15:0] C_EBREAK  = 16'h9002;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    PAD   = 2'd2
  } pk_state_e;

  // x8..x15 are the registers reachable through 3-bit RVC fields
  function automatic logic is_prime(input logic [4:0] r);
    return r[4:3] == 2'b01;
  endfunction

  // 12-bit immediate representable as a 6-bit signed value
  function automatic logic fits_s6(input logic [11:0] v);
    return (v[11:5] == 7'h00) || (v[11:5] == 7'h7f);
  endfunction

endpackage

// File: rtl/rv32torv16.sv
// Combinational RV32I -> RV32C compressor.
//   instr     : 32-bit RV32I instruction
//   comp_ctrl : 1 allows c.j/c.jal/c.beqz/c.bnez/c.jr/c.jalr
//   c16       : 16-bit encoding (valid only when c_ok)
//   c_ok      : instr is the canonical expansion of a legal RVC instruction
module rv32torv16
  import rvc_pkg::*;
(
  input  logic [31:0] instr,
  input  logic        comp_ctrl,
  output logic [15:0] c16,
  output logic        c_ok
);

  logic [6:0]  opc;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [11:0] imm_i;
  logic [11:0] imm_s;
  logic [12:1] imm_b;
  logic [20:1] imm_j;

  assign opc   = instr[6:0];
  assign rd    = instr[11:7];
  assign f3    = instr[14:12];
  assign rs1   = instr[19:15];
  assign rs2   = instr[24:20];
  assign f7    = instr[31:25];
  assign imm_i = instr[31:20];
  assign imm_s = {instr[31:25], instr[11:7]};
  assign imm_b = {instr[31], instr[7], instr[30:25], instr[11:8]};
  assign imm_j = {instr[31], instr[19:12], instr[20], instr[30:21]};

  // Field-match and re-encode; the first matching form wins where two forms overlap
  always_comb begin
    c16  = '0;
    c_ok = 1'b0;
    case (opc)
      OPC_OP_IMM: begin
        if (instr == RV_NOP) begin
          c16 = CNOP; c_ok = 1'b1;
        end else if (f3 == F3_ADD) begin
          if (rs1 == 5'd2 && is_prime(rd) && imm_i[11:10] == 2'b00 &&
              imm_i[1:0] == 2'b00 && imm_i != 12'd0) begin
            c16 = {3'b000, imm_i[5:4], imm_i[9:6], imm_i[2], imm_i[3], rd[2:0], 2'b00};
            c_ok = 1'b1;
          end else if (rd != 5'd0 && rs1 == rd && fits_s6(imm_i) && imm_i != 12'd0) begin
            c16 = {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
            c_ok = 1'b1;
          end else if (rd != 5'd0 && rs1 == 5'd0 && fits_s6(imm_i)) begin
            c16 = {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
            c_ok = 1'b1;
          end else if (rd == 5'd2 && rs1 == 5'd2 && imm_i[3:0] == 4'd0 && imm_i != 12'd0 &&
                       (imm_i[11:9] == 3'b000 || imm_i[11:9] == 3'b111)) begin
            c16 = {3'b011, imm_i[9], 5'd2, imm_i[4], imm_i[6], imm_i[8:7], imm_i[5], 2'b01};
            c_ok = 1'b1;
          end
        end else if (f3 == F3_SLL) begin
          if (f7 == F7_BASE && rd != 5'd0 && rs1 == rd && rs2 != 5'd0) begin
            c16 = {3'b000, 1'b0, rd, rs2, 2'b10};
            c_ok = 1'b1;
          end
        end else if (f3 == F3_SRX) begin
          // shamt[5] lives in f7[0], so requiring an exact f7 keeps it zero
          if (is_prime(rd) && rs1 == rd && rs2 != 5'd0) begin
            if (f7 == F7_BASE) begin
              c16 = {3'b100, 1'b0, 2'b00, rd[2:0], rs2, 2'b01};
              c_ok = 1'b1;
            end else if (f7 == F7_ALT) begin
              c16 = {3'b100, 1'b0, 2'b01, rd[2:0], rs2, 2'b01};
              c_ok = 1'b1;
            end
          end
        end else if (f3 == F3_AND) begin
          if (is_prime(rd) && rs1 == rd && fits_s6(imm_i)) begin
            c16 = {3'b100, imm_i[5], 2'b10, rd[2:0], imm_i[4:0], 2'b01};
            c_ok = 1'b1;
          end
        end
      end

      OPC_LUI: begin
        if (rd != 5'd0 && rd != 5'd2 && instr[17:12] != 6'd0 &&
            (instr[31:17] == 15'h0000 || instr[31:17] == 15'h7fff)) begin
          c16 = {3'b011, instr[17], rd, instr[16:12], 2'b01};
          c_ok = 1'b1;
        end
      end

      OPC_LOAD: begin
        if (f3 == F3_W && imm_i[1:0] == 2'b00) begin
          if (is_prime(rs1) && is_prime(rd) && imm_i[11:7] == 5'd0) begin
            c16 = {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
            c_ok = 1'b1;
          end else if (rs1 == 5'd2 && rd != 5'd0 && imm_i[11:8] == 4'd0) begin
            c16 = {3'b010, imm_i[5], rd, imm_i[4:2], imm_i[7:6], 2'b10};
            c_ok = 1'b1;
          end
        end
      end

      OPC_STORE: begin
        if (f3 == F3_W && imm_s[1:0] == 2'b00) begin
          if (is_prime(rs1) && is_prime(rs2) && imm_s[11:7] == 5'd0) begin
            c16 = {3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00};
            c_ok = 1'b1;
          end else if (rs1 == 5'd2 && imm_s[11:8] == 4'd0) begin
            c16 = {3'b110, imm_s[5:2], imm_s[7:6], rs2, 2'b10};
            c_ok = 1'b1;
          end
        end
      end

      OPC_OP: begin
        if (f7 == F7_BASE && f3 == F3_ADD) begin
          if (rd != 5'd0 && rs2 != 5'd0 && rs1 == 5'd0) begin
            c16 = {3'b100, 1'b0, rd, rs2, 2'b10};
            c_ok = 1'b1;
          end else if (rd != 5'd0 && rs2 != 5'd0 && rs1 == rd) begin
            c16 = {3'b100, 1'b1, rd, rs2, 2'b10};
            c_ok = 1'b1;
          end
        end else if (is_prime(rd) && rs1 == rd && is_prime(rs2)) begin
          if (f7 == F7_ALT && f3 == F3_ADD) begin
            c16 = {3'b100, 1'b0, 2'b11, rd[2:0], 2'b00, rs2[2:0], 2'b01};
            c_ok = 1'b1;
          end else if (f7 == F7_BASE && f3 == F3_XOR) begin
            c16 = {3'b100, 1'b0, 2'b11, rd[2:0], 2'b01, rs2[2:0], 2'b01};
            c_ok = 1'b1;
          end else if (f7 == F7_BASE && f3 == F3_OR) begin
            c16 = {3'b100, 1'b0, 2'b11, rd[2:0], 2'b10, rs2[2:0], 2'b01};
            c_ok = 1'b1;
          end else if (f7 == F7_BASE && f3 == F3_AND) begin
            c16 = {3'b100, 1'b0, 2'b11, rd[2:0], 2'b11, rs2[2:0], 2'b01};
            c_ok = 1'b1;
          end
        end
      end

      OPC_JAL: begin
        // offset must fit the 12-bit signed CJ range
        if (comp_ctrl && (rd == 5'd0 || rd == 5'd1) &&
            (imm_j[20:11] == 10'h000 || imm_j[20:11] == 10'h3ff)) begin
          c16 = {(rd == 5'd0) ? 3'b101 : 3'b001, imm_j[11], imm_j[4], imm_j[9:8],
                 imm_j[10], imm_j[6], imm_j[7], imm_j[3:1], imm_j[5], 2'b01};
          c_ok = 1'b1;
        end
      end

      OPC_JALR: begin
        if (comp_ctrl && f3 == 3'b000 && imm_i == 12'd0 && rs1 != 5'd0 &&
            (rd == 5'd0 || rd == 5'd1)) begin
          c16 = {3'b100, rd[0], rs1, 5'd0, 2'b10};
          c_ok = 1'b1;
        end
      end

      OPC_BRANCH: begin
        if (comp_ctrl && (f3 == F3_BEQ || f3 == F3_BNE) && rs2 == 5'd0 && is_prime(rs1) &&
            (imm_b[12:8] == 5'h00 || imm_b[12:8] == 5'h1f)) begin
          c16 = {(f3 == F3_BEQ) ? 3'b110 : 3'b111, imm_b[8], imm_b[4:3], rs1[2:0],
                 imm_b[7:6], imm_b[2:1], imm_b[5], 2'b01};
          c_ok = 1'b1;
        end
      end

      OPC_SYSTEM: begin
        if (instr == RV_EBREAK) begin
          c16 = C_EBREAK; c_ok = 1'b1;
        end
      end

      default: begin
        c16  = '0;
        c_ok = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rv32_compress_packer.sv
// Compresses an RV32I instruction stream to RVC where possible and packs the
// result little-endian into 32-bit words.
//   clk, rst_n          : clock, async active-low reset
//   comp_en             : 0 emits every instruction as 32-bit
//   in_valid/in_ready   : input handshake for in_instr/in_last
//   out_valid/out_ready : output handshake for out_word ([15:0] = lower address)
//   done                : pulse after the final word of a stream is accepted
//   comp_cnt            : saturating count of instructions emitted as 16-bit
module rv32_compress_packer
  import rvc_pkg::*;
#(
  parameter bit          COMP_CTRL = 1'b1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             comp_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_word,
  output logic             done,
  output logic [CNT_W-1:0] comp_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  pk_state_e   state;
  logic [15:0] res;
  logic        last_word;
  logic [15:0] c16;
  logic        c_ok;
  logic        out_free;
  logic        in_fire;
  logic        is16;

  rv32torv16 u_cmp (
    .instr     (in_instr),
    .comp_ctrl (COMP_CTRL),
    .c16       (c16),
    .c_ok      (c_ok)
  );

  assign out_free = !out_valid || out_ready;
  assign in_ready = (state != PAD) && out_free;
  assign in_fire  = in_valid && in_ready;
  assign is16     = comp_en && c_ok;

  // Packing FSM, residual halfword, output register and counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      res       <= '0;
      out_valid <= 1'b0;
      out_word  <= '0;
      last_word <= 1'b0;
      done      <= 1'b0;
      comp_cnt  <= '0;
    end else begin
      done <= 1'b0;
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        last_word <= 1'b0;
        done      <= last_word;
      end

      // Later assignments below override the acceptance clear above
      if (state == PAD) begin
        if (out_free) begin
          out_word  <= {CNOP, res};
          out_valid <= 1'b1;
          last_word <= 1'b1;
          state     <= EMPTY;
        end
      end else if (in_fire) begin
        if (is16 && comp_cnt != CNT_MAX) begin
          comp_cnt <= comp_cnt + CNT_W'(1);
        end
        case (state)
          EMPTY: begin
            if (is16) begin
              res   <= c16;
              state <= in_last ? PAD : HALF;
            end else begin
              out_word  <= in_instr;
              out_valid <= 1'b1;
              last_word <= in_last;
            end
          end
          HALF: begin
            if (is16) begin
              out_word  <= {c16, res};
              out_valid <= 1'b1;
              last_word <= in_last;
              state     <= EMPTY;
            end else begin
              // low half completes this word, high half becomes the new residual
              out_word  <= {in_instr[15:0], res};
              out_valid <= 1'b1;
              res       <= in_instr[31:16];
              state     <= in_last ? PAD : HALF;
            end
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rv32_compress_packer.sv
// Directed self-checking bench for rv32_compress_packer.
module tb_rv32_compress_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        comp_en = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_word;
  logic        done;
  logic [15:0] comp_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  logic [31:0] words[$];
  int          wcyc[$];

  // {rv32 instruction, expected rvc encoding}
  logic [47:0] cvec[26] = '{
    48'h01010413_0800, 48'h3fc10413_1fe0, 48'h00442483_4044, 48'h00942423_c404,
    48'h00000013_0001, 48'hfff50513_157d, 48'h008000ef_2021, 48'hfffff06f_bffd,
    48'h00500513_4515, 48'hfc010113_7139, 48'h00001537_6505, 48'h00345413_800d,
    48'h4014d493_8485, 48'hff047413_9841, 48'h40940433_8c05, 48'h00b57533_8d6d,
    48'h00040463_c401, 48'hfe049ee3_fcf5, 48'h00251513_050a, 48'h00c12083_40b2,
    48'h00008067_8082, 48'h000500e7_9502, 48'h00b00533_852e, 48'h00b50533_952e,
    48'h00100073_9002, 48'h00112223_c206
  };
  // just outside an RVC range/alignment/register rule: must stay 32-bit
  logic [31:0] nvec[7] = '{
    32'h40010413, 32'h00242483, 32'h02050513, 32'h0010006f,
    32'h00001137, 32'h10040063, 32'h007302b3
  };

  rv32_compress_packer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .comp_en   (comp_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .done      (done),
    .comp_cnt  (comp_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Values at the negedge are the ones the next posedge will act on
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      words.push_back(out_word);
      wcyc.push_back(cyc);
    end
    if (done) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input int i);
    if (i < words.size()) return words[i];
    return 32'hdead_beef;
  endfunction

  function automatic int cyc_at(input int i);
    if (i < wcyc.size()) return wcyc[i];
    return -1000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic last);
    int  n  = 0;
    logic acc = 1'b0;
    in_valid = 1'b1;
    in_instr = ins;
    in_last  = last;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      n++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_eq("in_accept", 32'(acc), 32'd1);
  endtask

  task automatic wait_words(input int n);
    int k = 0;
    while (words.size() < n && k < 60) begin
      @(negedge clk);
      k++;
    end
    repeat (3) tick();
    check_eq("word_count", 32'(words.size()), 32'(n));
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int base;
    int d0;

    // reset state
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_word", out_word, 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_comp_cnt", 32'(comp_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // two compressible instructions pack into one word
    base = words.size();
    d0 = done_cnt;
    send(32'h01010413, 1'b0);
    send(32'h00442483, 1'b0);
    wait_words(base + 1);
    check_eq("pair_word", word_at(base), 32'h40440800);
    check_eq("pair_cnt", 32'(comp_cnt), 32'd2);
    check_eq("pair_no_done", 32'(done_cnt - d0), 32'd0);

    // non-compressible from EMPTY passes through
    base = words.size();
    send(32'h007302b3, 1'b0);
    wait_words(base + 1);
    check_eq("add_word", word_at(base), 32'h007302b3);
    check_eq("add_cnt", 32'(comp_cnt), 32'd2);

    // 16b then 32b with in_last: straddle plus c.nop pad
    base = words.size();
    d0 = done_cnt;
    send(32'h00500513, 1'b0);
    send(32'h007302b3, 1'b1);
    wait_words(base + 2);
    check_eq("last_w0", word_at(base), 32'h02b34515);
    check_eq("last_w1", word_at(base + 1), 32'h00010073);
    check_eq("last_done", 32'(done_cnt - d0), 32'd1);
    check_eq("last_cnt", 32'(comp_cnt), 32'd3);

    // bypass mode
    do_reset();
    comp_en = 1'b0;
    base = words.size();
    d0 = done_cnt;
    send(32'h00000013, 1'b1);
    wait_words(base + 1);
    check_eq("bypass_word", word_at(base), 32'h00000013);
    check_eq("bypass_cnt", 32'(comp_cnt), 32'd0);
    check_eq("bypass_done", 32'(done_cnt - d0), 32'd1);
    comp_en = 1'b1;

    // backpressure: output stalled 5 cycles, then full rate
    base = words.size();
    d0 = done_cnt;
    out_ready = 1'b0;
    fork
      begin
        send(32'h007302b3, 1'b0);
        send(32'h005201b3, 1'b0);
        send(32'h00838333, 1'b0);
        send(32'h123452b7, 1'b1);
      end
      begin
        int k = 0;
        @(negedge clk);
        while (!out_valid && k < 20) begin
          @(negedge clk);
          k++;
        end
        for (int i = 0; i < 5; i++) begin
          check_eq($sformatf("stall_word%0d", i), out_word, 32'h007302b3);
          check_eq($sformatf("stall_ready%0d", i), 32'(in_ready), 32'd0);
          @(negedge clk);
        end
        tick();
        out_ready = 1'b1;
      end
    join
    wait_words(base + 4);
    check_eq("bp_w0", word_at(base), 32'h007302b3);
    check_eq("bp_w1", word_at(base + 1), 32'h005201b3);
    check_eq("bp_w2", word_at(base + 2), 32'h00838333);
    check_eq("bp_w3", word_at(base + 3), 32'h123452b7);
    check_eq("bp_rate", 32'(cyc_at(base + 3) - cyc_at(base)), 32'd3);
    check_eq("bp_done", 32'(done_cnt - d0), 32'd1);

    // encoding table: each compressible followed by c.nop
    base = words.size();
    foreach (cvec[i]) begin
      send(cvec[i][47:16], 1'b0);
      send(32'h00000013, 1'b0);
    end
    wait_words(base + 26);
    foreach (cvec[i]) begin
      check_eq($sformatf("cvec%0d", i), word_at(base + i), {16'h0001, cvec[i][15:0]});
    end
    check_eq("table_cnt", 32'(comp_cnt), 32'd52);

    // boundary cases that must remain 32-bit
    base = words.size();
    foreach (nvec[i]) send(nvec[i], 1'b0);
    wait_words(base + 7);
    foreach (nvec[i]) begin
      check_eq($sformatf("nvec%0d", i), word_at(base + i), nvec[i]);
    end
    check_eq("nvec_cnt", 32'(comp_cnt), 32'd52);

    // reset while a residual halfword is held
    send(32'h00500513, 1'b0);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("midrst_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_cnt", 32'(comp_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    base = words.size();
    send(32'h007302b3, 1'b1);
    wait_words(base + 1);
    check_eq("midrst_word", word_at(base), 32'h007302b3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
